// File: rtl/pts_tx_ctrl.sv
// Transmit sequencer for a parallel-to-serial shift register.
// Captures a word on handshake, loads it, then paces NUM_BITS shift strobes.
module pts_tx_ctrl #(
  parameter int NUM_BITS   = 8,
  parameter int BIT_PERIOD = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                stall,
  output logic                tx_ready,
  output logic [NUM_BITS-1:0] pts_data,
  output logic                load_enable,
  output logic                shift_enable,
  output logic                busy,
  output logic                byte_done
);

  localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [PW-1:0] PER_MAX = PW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] per_cnt;
  logic [PW-1:0] per_nx;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nx;
  logic          xfer;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      pts_data <= '0;
      per_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      state   <= state_nx;
      per_cnt <= per_nx;
      bit_cnt <= bit_nx;
      if (xfer) pts_data <= tx_data;
    end
  end

  always_comb begin
    state_nx     = state;
    per_nx       = per_cnt;
    bit_nx       = bit_cnt;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    busy         = 1'b0;
    byte_done    = 1'b0;
    tx_ready     = (state == IDLE) || (state == DONE);
    xfer         = tx_valid && tx_ready;
    unique case (state)
      IDLE: begin
        if (xfer) state_nx = LOAD;
      end
      LOAD: begin
        load_enable = 1'b1;
        busy        = 1'b1;
        per_nx      = '0;
        bit_nx      = '0;
        state_nx    = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        // stall freezes both counters so every later event slips one cycle
        if (!stall) begin
          if (per_cnt == PER_MAX) begin
            shift_enable = 1'b1;
            per_nx       = '0;
            bit_nx       = bit_cnt + 1'b1;
            if (bit_cnt == BIT_MAX) state_nx = DONE;
          end else begin
            per_nx = per_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        byte_done = 1'b1;
        state_nx  = xfer ? LOAD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Directed bench for pts_tx_ctrl: BIT_PERIOD=1 and BIT_PERIOD=4 instances,
// each followed by a small shift-register model to recover the serial word.
module tb_pts_tx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       v1, st1, v4, st4;
  logic [7:0] d1, d4;
  logic       rdy1, ld1, sh1, bz1, dn1;
  logic       rdy4, ld4, sh4, bz4, dn4;
  logic [7:0] pd1, pd4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pts_tx_ctrl #(.NUM_BITS(8), .BIT_PERIOD(1)) u1 (
    .clk(clk), .n_rst(n_rst), .tx_valid(v1), .tx_data(d1),
    .stall(st1), .tx_ready(rdy1), .pts_data(pd1),
    .load_enable(ld1), .shift_enable(sh1), .busy(bz1),
    .byte_done(dn1)
  );

  pts_tx_ctrl #(.NUM_BITS(8), .BIT_PERIOD(4)) u4 (
    .clk(clk), .n_rst(n_rst), .tx_valid(v4), .tx_data(d4),
    .stall(st4), .tx_ready(rdy4), .pts_data(pd4),
    .load_enable(ld4), .shift_enable(sh4), .busy(bz4),
    .byte_done(dn4)
  );

  // MSB-first shift register models fed by the strobes
  logic [7:0] sr1 = '0, got1 = '0, sr4 = '0, got4 = '0;
  int n_sh1 = 0;
  int n_sh4 = 0;
  int n_ls  = 0;

  always @(posedge clk) begin
    if (ld1 && sh1) n_ls <= n_ls + 1;
    if (ld1) sr1 <= pd1;
    else if (sh1) begin
      got1  <= {got1[6:0], sr1[7]};
      sr1   <= {sr1[6:0], 1'b0};
      n_sh1 <= n_sh1 + 1;
    end
  end

  always @(posedge clk) begin
    if (ld4) sr4 <= pd4;
    else if (sh4) begin
      got4  <= {got4[6:0], sr4[7]};
      sr4   <= {sr4[6:0], 1'b0};
      n_sh4 <= n_sh4 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic exp_sh;
    n_rst = 1'b0;
    v1 = 1'b0; d1 = '0; st1 = 1'b0;
    v4 = 1'b0; d4 = '0; st4 = 1'b0;

    // reset state
    tick();
    tick();
    #1;
    chk("rst_ready", rdy1, 1'b1);
    chk("rst_load", ld1, 1'b0);
    chk("rst_shift", sh1, 1'b0);
    chk("rst_busy", bz1, 1'b0);
    chk("rst_done", dn1, 1'b0);
    chk("rst_pts", pd1, 8'h00);
    chk("rst_ready4", rdy4, 1'b1);
    chk("rst_busy4", bz4, 1'b0);
    tick();
    n_rst = 1'b1;

    // single word, BIT_PERIOD=1
    tick();
    base = n_sh1;
    v1 = 1'b1; d1 = 8'b01010100;
    #1;
    chk("w1_c0_ready", rdy1, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      v1 = 1'b0;
      #1;
      chk($sformatf("w1_load_c%0d", c), ld1, c == 1);
      chk($sformatf("w1_shift_c%0d", c), sh1, c >= 2 && c <= 9);
      chk($sformatf("w1_done_c%0d", c), dn1, c == 10);
      chk($sformatf("w1_busy_c%0d", c), bz1, c >= 1 && c <= 9);
      chk($sformatf("w1_pts_c%0d", c), pd1, 8'h54);
    end
    chk("w1_nshift", n_sh1 - base, 8);
    chk("w1_serial", got1, 8'h54);

    // BIT_PERIOD=4, word 0x3C
    tick();
    base = n_sh4;
    v4 = 1'b1; d4 = 8'b00111100;
    #1;
    chk("w4_c0_ready", rdy4, 1'b1);
    for (int c = 1; c <= 35; c++) begin
      tick();
      v4 = 1'b0;
      #1;
      exp_sh = (c >= 5) && (c <= 33) && ((c - 1) % 4 == 0);
      chk($sformatf("w4_load_c%0d", c), ld4, c == 1);
      chk($sformatf("w4_shift_c%0d", c), sh4, exp_sh);
      chk($sformatf("w4_done_c%0d", c), dn4, c == 34);
      chk($sformatf("w4_busy_c%0d", c), bz4, c >= 1 && c <= 33);
      chk($sformatf("w4_pts_c%0d", c), pd4, 8'h3C);
    end
    chk("w4_nshift", n_sh4 - base, 8);
    chk("w4_serial", got4, 8'h3C);

    // back-to-back with 0xFF presented while busy
    tick();
    base = n_sh1;
    v1 = 1'b1; d1 = 8'h54;
    #1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c <= 9) d1 = 8'hFF;
      else if (c == 10) d1 = 8'h3C;
      else v1 = 1'b0;
      #1;
      if (c >= 2 && c <= 9) begin
        chk($sformatf("bb_ready_c%0d", c), rdy1, 1'b0);
      end
      if (c == 10) chk("bb_nshift1", n_sh1 - base, 8);
      if (c == 11) chk("bb_serial1", got1, 8'h54);
      chk($sformatf("bb_load_c%0d", c), ld1, c == 1 || c == 11);
      chk($sformatf("bb_done_c%0d", c), dn1, c == 10 || c == 20);
      chk($sformatf("bb_busy_c%0d", c), bz1,
          (c >= 1 && c <= 9) || (c >= 11 && c <= 19));
      chk($sformatf("bb_pts_c%0d", c), pd1, c <= 10 ? 8'h54 : 8'h3C);
    end
    chk("bb_ready_end", rdy1, 1'b1);
    chk("bb_nshift", n_sh1 - base, 16);
    chk("bb_serial2", got1, 8'h3C);

    // stall for 3 cycles after the 4th shift
    tick();
    base = n_sh1;
    v1 = 1'b1; d1 = 8'hA5;
    #1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      v1  = 1'b0;
      st1 = (c >= 6 && c <= 8);
      #1;
      exp_sh = (c >= 2 && c <= 5) || (c >= 9 && c <= 12);
      chk($sformatf("st_shift_c%0d", c), sh1, exp_sh);
      chk($sformatf("st_done_c%0d", c), dn1, c == 13);
    end
    st1 = 1'b0;
    chk("st_nshift", n_sh1 - base, 8);
    chk("st_serial", got1, 8'hA5);

    // reset after the 3rd shift
    tick();
    base = n_sh1;
    v1 = 1'b1; d1 = 8'hC3;
    #1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      v1    = 1'b0;
      n_rst = (c != 4);
      #1;
      if (c == 4) chk("mr_shift3", n_sh1 - base, 2);
      if (c == 5) begin
        chk("mr_ready", rdy1, 1'b1);
        chk("mr_load", ld1, 1'b0);
        chk("mr_shift", sh1, 1'b0);
        chk("mr_busy", bz1, 1'b0);
        chk("mr_pts", pd1, 8'h00);
      end
      if (c >= 5) begin
        chk($sformatf("mr_done_c%0d", c), dn1, 1'b0);
        chk($sformatf("mr_idle_c%0d", c), bz1, 1'b0);
      end
    end
    chk("mr_nshift", n_sh1 - base, 3);
    base = n_sh1;
    v1 = 1'b1; d1 = 8'h96;
    #1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      v1 = 1'b0;
      #1;
      chk($sformatf("mr2_shift_c%0d", c), sh1, c >= 2 && c <= 9);
      chk($sformatf("mr2_done_c%0d", c), dn1, c == 10);
    end
    chk("mr2_nshift", n_sh1 - base, 8);
    chk("mr2_serial", got1, 8'h96);
    chk("no_load_shift_overlap", n_ls, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pts_tx_ctrl.md
# pts_tx_ctrl

Transmit sequencer for `flex_pts_sr`, the parallel-to-serial shift register in the SD/USB datapath. It accepts words from an upstream requester over a valid/ready handshake, holds each word stable on the register's `parallel_in`, pulses `load_enable` for one cycle, and then issues exactly NUM_BITS `shift_enable` pulses at a programmable bit period. It reports word completion and supports a stall input so that line-level logic can hold the bit timing.

## Interface
- NUM_BITS, 8, word width; must match the shift register's NUM_BITS (≥2)
- BIT_PERIOD, 1, clock cycles per serial bit (≥1)
- clk  in  1  system clock; all state updates on the rising edge
- n_rst  in  1  reset; one clock, synchronous, active-low; sampled on the rising edge of clk
- tx_valid  in  1  requester has a word on tx_data
- tx_data  in  NUM_BITS  word to transmit; captured on handshake
- stall  in  1  freeze bit timing while in SHIFT
- tx_ready  out  1  controller can accept a word this cycle
- pts_data  out  NUM_BITS  captured word; drives shift register `parallel_in`
- load_enable  out  1  one-cycle load strobe to the shift register
- shift_enable  out  1  one-cycle shift strobe to the shift register
- busy  out  1  a word is in flight (LOAD or SHIFT)
- byte_done  out  1  one-cycle pulse: the NUM_BITS-th shift has completed

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- Registers:
  - `state`
  - `pts_data` (NUM_BITS)
  - `per_cnt` (clog2(BIT_PERIOD) bits, minimum 1)
  - `bit_cnt` (clog2(NUM_BITS+1) bits)
- Handshake:
  - `tx_ready` = 1 in IDLE or DONE; it is decoded from `state` only.
  - A transfer occurs on an edge where `tx_valid` and `tx_ready` are both 1.
  - On a transfer, `pts_data` ← `tx_data` and the next state is LOAD.
  - `tx_valid` and `tx_data` are ignored in LOAD and SHIFT. `pts_data` holds until the next transfer.
- IDLE:
  - transfer → LOAD; otherwise stay in IDLE.
- LOAD:
  - `load_enable` = 1 and `busy` = 1.
  - `per_cnt` ← 0 and `bit_cnt` ← 0.
  - Next state is always SHIFT.
- SHIFT (`busy` = 1):
  - If `stall` = 1: `per_cnt` and `bit_cnt` hold and `shift_enable` = 0.
  - Else if `per_cnt` = BIT_PERIOD-1: `shift_enable` = 1, `per_cnt` ← 0, `bit_cnt` ← `bit_cnt`+1.
    - If `bit_cnt` = NUM_BITS-1, the next state is DONE.
  - Else: `per_cnt` ← `per_cnt`+1.
  - `shift_enable` = (state==SHIFT) & (`per_cnt`==BIT_PERIOD-1) & !`stall`. This is the only output combinationally dependent on an input.
- DONE:
  - `byte_done` = 1 and `tx_ready` = 1.
  - transfer → LOAD (back-to-back); otherwise → IDLE.
- No counter ever wraps. `bit_cnt` never exceeds NUM_BITS, and `per_cnt` never exceeds BIT_PERIOD-1.
- Reset values after the reset edge:
  - state = IDLE and `pts_data` = 0.
  - `tx_ready` = 1.
  - `load_enable`, `shift_enable`, `busy` and `byte_done` = 0.
  - Both counters = 0.
- Reset mid-word: the word is abandoned, with no `byte_done` and no further strobes. The shift register is reset by the same `n_rst`.

## Timing
- Handshake edge at the end of cycle 0:
  - cycle 1: LOAD, `load_enable` = 1.
  - cycles 2 … 1+NUM_BITS·BIT_PERIOD: SHIFT.
  - `shift_enable` is high in cycle 1+k·BIT_PERIOD, for k = 1…NUM_BITS (no stall).
  - cycle 2+NUM_BITS·BIT_PERIOD: DONE, `byte_done` = 1.
- Each stalled SHIFT cycle extends every later event by exactly one cycle.
- Back-to-back transfers in DONE give a word period of NUM_BITS·BIT_PERIOD+2 cycles.
- There are never two consecutive `shift_enable` cycles when BIT_PERIOD > 1.
- `load_enable` and `shift_enable` are never high in the same cycle.

## Test plan
- **Single word, BIT_PERIOD=1:**
  - Reset, then `tx_data` = 8'b01010100 with `tx_valid` held for one handshake.
  - Required: `load_enable` only in cycle 1; `shift_enable` in cycles 2–9; `byte_done` in cycle 10.
  - Required: `pts_data` = 8'h54 throughout; the shift register's `serial_out` sequence matches 0x54.
- **BIT_PERIOD=4, word 8'b00111100:**
  - Required: `shift_enable` in cycles 5, 9, …, 33; `byte_done` in cycle 34; `busy` high in cycles 1–33.
- **Back-to-back:**
  - `tx_valid` held high with 0x54, then 0x3C presented in the DONE cycle.
  - Required: second `load_enable` in the cycle after `byte_done`; the second word is captured with no IDLE cycle in between.
- **Busy ignore:**
  - Change `tx_data` to 0xFF with `tx_valid` = 1 during SHIFT.
  - Required: `tx_ready` = 0, `pts_data` unchanged, shift count still exactly 8.
- **Stall:**
  - BIT_PERIOD=1; assert `stall` for 3 cycles after the 4th shift.
  - Required: no `shift_enable` during the stall; `byte_done` delayed by exactly 3 cycles; 8 shifts total.
- **Reset mid-word:**
  - Drop `n_rst` for one edge after the 3rd shift.
  - Required: all outputs at reset values on the next cycle, `tx_ready` = 1, no `byte_done`; a new word then completes normally.
